writeback_pc_rf: RTL and testbench

- Parametrised successor to the writeback-stage PC register: owns the program counter, the general-purpose register file and a retired-instruction counter.
- Sits at the end of the single-cycle/multicycle datapath; takes the computed next PC and ALU/load result and commits them on the clock edge.
- Adds stall, branch redirect, register writeback with read bypass, and retirement counting.

---
 rtl/writeback_pc_rf.sv | 115 +++++++++++
 tb/tb_writeback_pc_rf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_pc_rf.sv
// Writeback-stage state: program counter, register file and retired-instruction counter.
// Optional feature macro: WB_MISALIGN_TRAP_EN (misaligned redirect loads TRAP_VEC, pulses trap).
module writeback_pc_rf #(
    parameter int unsigned      XLEN      = 32,
    parameter int unsigned      NREG      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = 32'h00000000,
    parameter int unsigned      PC_INC    = 4,
    parameter int unsigned      CNT_W     = 32,
    parameter logic [XLEN-1:0]  TRAP_VEC  = 32'h00000080,
    localparam int unsigned     AW        = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rstd,
    input  logic             stall,
    input  logic             redirect,
    input  logic [XLEN-1:0]  nextpc,
    input  logic             wr_en,
    input  logic [AW-1:0]    wra,
    input  logic [XLEN-1:0]  result,
    input  logic             retire,
    input  logic [AW-1:0]    rs_a,
    input  logic [AW-1:0]    rs_b,
    output logic [XLEN-1:0]  rd_a,
    output logic [XLEN-1:0]  rd_b,
    output logic [XLEN-1:0]  pc,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  rf_q [NREG];
    logic             wr_fire;
    logic [XLEN-1:0]  redir_pc;
    logic             misalign;

    // A write commits only when not stalled and not aimed at the hardwired zero register
    assign wr_fire = wr_en && !stall && (wra != '0);

`ifdef WB_MISALIGN_TRAP_EN
    logic trap_q;

    // Misalignment only meaningful for word-sized sequential steps
    assign misalign = (PC_INC == 4) && (nextpc[1:0] != 2'b00);
    assign redir_pc = misalign ? TRAP_VEC : nextpc;

    // Trap pulse lasts exactly the cycle after a misaligned redirect
    always_ff @(posedge clk) begin
        if (rstd) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= redirect && misalign;
        end
    end

    assign trap = trap_q;
`else
    assign misalign = 1'b0;
    assign redir_pc = nextpc;
    assign trap     = 1'b0;
`endif

    // PC: reset > redirect > stall > sequential increment (wraps silently)
    always_ff @(posedge clk) begin
        if (rstd) begin
            pc_q <= RESET_VEC;
        end else if (redirect) begin
            pc_q <= redir_pc;
        end else if (!stall) begin
            pc_q <= pc_q + XLEN'(PC_INC);
        end
    end

    // Retirement counter; redirect does not block it, stall does
    always_ff @(posedge clk) begin
        if (rstd) begin
            instret_q <= '0;
        end else if (retire && !stall) begin
            instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Register file with whole-array synchronous clear
    always_ff @(posedge clk) begin
        if (rstd) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_fire) begin
            rf_q[wra] <= result;
        end
    end

    // Combinational reads with write-through bypass; register 0 reads as zero
    always_comb begin
        rd_a = rf_q[rs_a];
        rd_b = rf_q[rs_b];
        if (wr_fire && (rs_a == wra)) begin
            rd_a = result;
        end
        if (wr_fire && (rs_b == wra)) begin
            rd_b = result;
        end
        if (rs_a == '0) begin
            rd_a = '0;
        end
        if (rs_b == '0) begin
            rd_b = '0;
        end
    end

    assign pc      = pc_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_writeback_pc_rf.sv
// Directed bench for writeback_pc_rf with a per-cycle reference model (CNT_W=4 for wrap).
module tb_writeback_pc_rf;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstd, stall, redirect, wr_en, retire;
    logic [XLEN-1:0]  nextpc, result;
    logic [AW-1:0]    wra, rs_a, rs_b;
    logic [XLEN-1:0]  rd_a, rd_b, pc;
    logic [CNT_W-1:0] instret;
    logic             trap;

    int n_checks = 0;
    int n_fail   = 0;

    writeback_pc_rf #(
        .XLEN     (XLEN),
        .NREG     (NREG),
        .RESET_VEC(32'h00000000),
        .PC_INC   (4),
        .CNT_W    (CNT_W),
        .TRAP_VEC (32'h00000080)
    ) dut (
        .clk     (clk),
        .rstd    (rstd),
        .stall   (stall),
        .redirect(redirect),
        .nextpc  (nextpc),
        .wr_en   (wr_en),
        .wra     (wra),
        .result  (result),
        .retire  (retire),
        .rs_a    (rs_a),
        .rs_b    (rs_b),
        .rd_a    (rd_a),
        .rd_b    (rd_b),
        .pc      (pc),
        .instret (instret),
        .trap    (trap)
    );

    always #5 clk = ~clk;

`ifdef WB_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    // Reference model: architectural state updated from the rules each edge
    bit          m_valid = 1'b0;
    int unsigned m_pc;
    int unsigned m_regs [NREG];
    int unsigned m_cnt;
    bit          m_trap;

    always @(posedge clk) begin
        if (rstd) begin
            m_valid = 1'b1;
            m_pc    = 0;
            m_cnt   = 0;
            m_trap  = 1'b0;
            foreach (m_regs[i]) m_regs[i] = 0;
        end else begin
            m_trap = 1'b0;
            if (redirect) begin
                if (TrapEn && (nextpc % 4 != 0)) begin
                    m_pc   = 32'h80;
                    m_trap = 1'b1;
                end else begin
                    m_pc = nextpc;
                end
            end else if (!stall) begin
                m_pc = m_pc + 4;
            end
            if (wr_en && !stall && wra != 0) m_regs[wra] = result;
            if (retire && !stall) m_cnt = (m_cnt + 1) % 16;
        end
    end

    function automatic int unsigned exp_rd(input logic [AW-1:0] a);
        if (a == 0) return 0;
        if (wr_en && !stall && wra == a && wra != 0) return result;
        return m_regs[a];
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every cycle once reset has established known state
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_pc", pc, m_pc);
            chk("m_instret", {28'd0, instret}, m_cnt);
            chk("m_trap", {31'd0, trap}, {31'd0, m_trap});
            chk("m_rd_a", rd_a, exp_rd(rs_a));
            chk("m_rd_b", rd_b, exp_rd(rs_b));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rstd = 0; stall = 0; redirect = 0; wr_en = 0; retire = 0;
        nextpc = '0; result = '0; wra = '0; rs_a = '0; rs_b = '0;
    endtask

    initial begin
        idle();
        rstd = 1;
        tick(); tick();
        rstd = 0;
        #1 chk("reset_pc", pc, 32'h0);
        chk("reset_instret", {28'd0, instret}, 32'd0);
        chk("reset_trap", {31'd0, trap}, 32'd0);
        tick(); chk("run_pc4", pc, 32'h4);
        tick(); chk("run_pc8", pc, 32'h8);
        tick(); chk("run_pcC", pc, 32'hC);
        chk("run_instret0", {28'd0, instret}, 32'd0);
        tick(); chk("run_pc10", pc, 32'h10);

        // Redirect beats stall, then stall holds
        redirect = 1; stall = 1; nextpc = 32'h12345678;
        tick(); chk("redir_stall", pc, 32'h12345678);
        redirect = 0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("stall_hold", pc, 32'h12345678);
        end
        stall = 0;

        // Writeback with same-cycle bypass on both ports
        wr_en = 1; wra = 5; result = 32'hDEADBEEF; rs_a = 5; rs_b = 5;
        #1 chk("bypass_a", rd_a, 32'hDEADBEEF);
        chk("bypass_b", rd_b, 32'hDEADBEEF);
        tick(); wr_en = 0;
        #1 chk("stored_a", rd_a, 32'hDEADBEEF);

        // Register 0 is hardwired
        wr_en = 1; wra = 0; result = 32'hFFFFFFFF; rs_a = 0;
        #1 chk("r0_bypass", rd_a, 32'h0);
        tick(); wr_en = 0;
        #1 chk("r0_after", rd_a, 32'h0);

        // Stalled write neither bypasses nor commits
        wr_en = 1; stall = 1; wra = 5; result = 32'h11111111; rs_a = 5;
        #1 chk("stall_nobypass", rd_a, 32'hDEADBEEF);
        tick(); wr_en = 0; stall = 0;
        #1 chk("stall_nowrite", rd_a, 32'hDEADBEEF);

        // Write to 6 while reading 6 and 5 on separate ports
        wr_en = 1; wra = 6; result = 32'hCAFE0006; rs_a = 6; rs_b = 5;
        #1 chk("dual_a", rd_a, 32'hCAFE0006);
        chk("dual_b", rd_b, 32'hDEADBEEF);
        tick(); wr_en = 0;

        // 17 retirements on a 4-bit counter wrap to 1
        retire = 1;
        for (int i = 0; i < 17; i++) tick();
        retire = 0;
        chk("cnt_wrap", {28'd0, instret}, 32'd1);

        // PC wraps past the top of the address space
        redirect = 1; nextpc = 32'hFFFFFFFC;
        tick(); redirect = 0;
        chk("pc_top", pc, 32'hFFFFFFFC);
        tick(); chk("pc_wrap", pc, 32'h0);

        // Reset overrides redirect mid-operation
        wr_en = 1; wra = 7; result = 32'h55; retire = 1;
        tick(); wr_en = 0;
        tick(); retire = 0;
        rs_a = 7;
        #1 chk("pre_rst_r7", rd_a, 32'h55);
        chk("pre_rst_cnt", {28'd0, instret}, 32'd3);
        rstd = 1; redirect = 1; nextpc = 32'h40;
        tick(); rstd = 0; redirect = 0;
        #1 chk("rst_pc", pc, 32'h0);
        chk("rst_r7", rd_a, 32'h0);
        chk("rst_cnt", {28'd0, instret}, 32'd0);

        // Misaligned redirect handling
        redirect = 1; nextpc = 32'h1002;
        tick(); redirect = 0; stall = 1;
`ifdef WB_MISALIGN_TRAP_EN
        chk("mis_pc", pc, 32'h80);
        chk("mis_trap", {31'd0, trap}, 32'd1);
`else
        chk("mis_pc", pc, 32'h1002);
        chk("mis_trap", {31'd0, trap}, 32'd0);
`endif
        tick(); chk("trap_pulse_end", {31'd0, trap}, 32'd0);
        stall = 0; redirect = 1; nextpc = 32'h1004;
        tick(); redirect = 0; stall = 1;
        chk("align_pc", pc, 32'h1004);
        chk("align_trap", {31'd0, trap}, 32'd0);

        // Reset in the trap cycle clears it
        stall = 0; redirect = 1; nextpc = 32'h2001;
        tick(); redirect = 0; rstd = 1;
        tick(); rstd = 0;
        #1 chk("trap_rst", {31'd0, trap}, 32'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
